// File: rtl/sample_ctrl_pkg.sv
// Shared definitions for the random-forest sample replay controller:
// state encoding, default geometry and index-width helpers.
package sample_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MARK   = 2'd1,
        ST_STREAM = 2'd2,
        ST_REWIND = 2'd3
    } state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_FEAT_CNT = 8;
    localparam int DEF_N_TREES  = 4;
    localparam int DEF_DEPTH    = 16;

    // Index width that never collapses to zero bits (N_TREES may be 1).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_FEAT_W = idx_w(DEF_FEAT_CNT);
    localparam int DEF_TREE_W = idx_w(DEF_N_TREES);
    localparam int DEF_OCC_W  = $clog2(DEF_DEPTH + 1);

endpackage

// File: rtl/sample_replay_ctrl.sv
// Loads feature words into the sample FIFO and replays each sample once per
// tree, rewinding the FIFO read pointer to the mark between passes.
module sample_replay_ctrl
    import sample_ctrl_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FEAT_CNT = DEF_FEAT_CNT,
    parameter int N_TREES  = DEF_N_TREES,
    parameter int DEPTH    = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_run,
    input  logic                        i_flush,
    input  logic                        i_in_vld,
    input  logic [DATA_W-1:0]           i_in_data,
    output logic                        o_in_rdy,
    output logic                        o_fifo_push,
    output logic [DATA_W-1:0]           o_fifo_rear,
    input  logic                        i_fifo_full,
    output logic                        o_fifo_pop,
    input  logic [DATA_W-1:0]           i_fifo_front,
    input  logic                        i_fifo_empty,
    output logic                        o_fifo_mark,
    output logic                        o_fifo_rrst,
    output logic                        o_fifo_flush,
    output logic                        o_feat_vld,
    output logic [DATA_W-1:0]           o_feat_data,
    input  logic                        i_feat_rdy,
    output logic [idx_w(FEAT_CNT)-1:0]  o_feat_idx,
    output logic [idx_w(N_TREES)-1:0]   o_tree_idx,
    output logic                        o_last,
    output logic                        o_sample_done,
    output logic [15:0]                 o_sample_cnt,
    output logic                        o_busy,
    output state_t                      o_state
);

    localparam int FEAT_W = idx_w(FEAT_CNT);
    localparam int TREE_W = idx_w(N_TREES);
    localparam int OCC_W  = $clog2(DEPTH + 1);

    state_t              state;
    logic [OCC_W-1:0]    occ;
    logic [OCC_W-1:0]    occ_next;
    logic [FEAT_W-1:0]   feat_idx;
    logic [TREE_W-1:0]   tree_idx;
    logic                final_pass;
    logic                retire;

    // Handshakes: a word moves on a cycle where its valid and ready are both
    // high. occ counts words pushed but not yet retired, so the marked region
    // being replayed can never be overwritten by upstream.
    assign o_in_rdy    = !i_fifo_full && (occ < OCC_W'(DEPTH)) && !i_flush && !rst;
    assign o_fifo_push = i_in_vld && o_in_rdy;
    assign o_fifo_rear = i_in_data;

    assign o_feat_vld  = (state == ST_STREAM) && !i_fifo_empty && !i_flush;
    assign o_fifo_pop  = o_feat_vld && i_feat_rdy;
    assign o_feat_data = i_fifo_front;
    assign o_last      = (state == ST_STREAM) && (feat_idx == FEAT_W'(FEAT_CNT - 1));

    assign final_pass  = (tree_idx == TREE_W'(N_TREES - 1));
    assign retire      = o_fifo_pop && o_last && final_pass;

    assign o_feat_idx  = feat_idx;
    assign o_tree_idx  = tree_idx;
    assign o_state     = state;

    always_comb begin
        occ_next = occ;
        if (o_fifo_push) occ_next = occ_next + OCC_W'(1);
        if (retire)      occ_next = occ_next - OCC_W'(FEAT_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            occ           <= '0;
            feat_idx      <= '0;
            tree_idx      <= '0;
            o_sample_cnt  <= '0;
            o_fifo_mark   <= 1'b0;
            o_fifo_rrst   <= 1'b0;
            o_fifo_flush  <= 1'b0;
            o_sample_done <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            o_fifo_mark   <= 1'b0;
            o_fifo_rrst   <= 1'b0;
            o_fifo_flush  <= 1'b0;
            o_sample_done <= 1'b0;
            if (i_flush) begin
                o_fifo_flush <= 1'b1;
                occ          <= '0;
                feat_idx     <= '0;
                tree_idx     <= '0;
                state        <= ST_IDLE;
                o_busy       <= 1'b0;
            end else begin
                occ <= occ_next;
                case (state)
                    ST_IDLE: begin
                        if (i_run) begin
                            state       <= ST_MARK;
                            o_fifo_mark <= 1'b1;
                            o_busy      <= 1'b1;
                        end
                    end
                    ST_MARK: begin
                        feat_idx <= '0;
                        state    <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (o_fifo_pop) begin
                            if (o_last) begin
                                feat_idx <= '0;
                                if (final_pass) begin
                                    tree_idx      <= '0;
                                    o_sample_done <= 1'b1;
                                    o_sample_cnt  <= o_sample_cnt + 16'd1;
                                    // i_run is only sampled here, at a sample boundary.
                                    if (i_run) begin
                                        state       <= ST_MARK;
                                        o_fifo_mark <= 1'b1;
                                    end else begin
                                        state  <= ST_IDLE;
                                        o_busy <= 1'b0;
                                    end
                                end else begin
                                    state       <= ST_REWIND;
                                    o_fifo_rrst <= 1'b1;
                                end
                            end else begin
                                feat_idx <= feat_idx + FEAT_W'(1);
                            end
                        end
                    end
                    ST_REWIND: begin
                        tree_idx <= tree_idx + TREE_W'(1);
                        feat_idx <= '0;
                        state    <= ST_STREAM;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_replay_ctrl.sv
// Bench for sample_replay_ctrl with a behavioural show-ahead FIFO beside it
// (mark / rewind / flush), a word scoreboard and a scenario table.
module tb_sample_replay_ctrl;
    import sample_ctrl_pkg::*;

    localparam int DW    = DEF_DATA_W;
    localparam int FC    = DEF_FEAT_CNT;
    localparam int NT    = DEF_N_TREES;
    localparam int DP    = DEF_DEPTH;
    localparam int FW    = DEF_FEAT_W;
    localparam int TW    = DEF_TREE_W;
    localparam int EXP_W = DW + FW + TW + 1;
    localparam int LAT   = 1 + NT * FC + (NT - 1);

    logic clk, rst, i_run, i_flush, i_in_vld, i_feat_rdy;
    logic [DW-1:0] i_in_data, i_fifo_front, o_fifo_rear, o_feat_data;
    logic o_in_rdy, o_fifo_push, i_fifo_full, o_fifo_pop, i_fifo_empty;
    logic o_fifo_mark, o_fifo_rrst, o_fifo_flush, o_feat_vld, o_last;
    logic o_sample_done, o_busy;
    logic [FW-1:0] o_feat_idx;
    logic [TW-1:0] o_tree_idx;
    logic [15:0]   o_sample_cnt;
    state_t        dbg_state;

    sample_replay_ctrl dut (
        .clk(clk), .rst(rst), .i_run(i_run), .i_flush(i_flush),
        .i_in_vld(i_in_vld), .i_in_data(i_in_data), .o_in_rdy(o_in_rdy),
        .o_fifo_push(o_fifo_push), .o_fifo_rear(o_fifo_rear), .i_fifo_full(i_fifo_full),
        .o_fifo_pop(o_fifo_pop), .i_fifo_front(i_fifo_front), .i_fifo_empty(i_fifo_empty),
        .o_fifo_mark(o_fifo_mark), .o_fifo_rrst(o_fifo_rrst), .o_fifo_flush(o_fifo_flush),
        .o_feat_vld(o_feat_vld), .o_feat_data(o_feat_data), .i_feat_rdy(i_feat_rdy),
        .o_feat_idx(o_feat_idx), .o_tree_idx(o_tree_idx), .o_last(o_last),
        .o_sample_done(o_sample_done), .o_sample_cnt(o_sample_cnt), .o_busy(o_busy),
        .o_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fmem [DP];
    logic [4:0]    wptr, rptr, mptr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0; rptr <= '0; mptr <= '0;
        end else if (o_fifo_flush) begin
            wptr <= '0; rptr <= '0; mptr <= '0;
        end else begin
            if (o_fifo_push) begin
                fmem[wptr[3:0]] <= o_fifo_rear;
                wptr <= wptr + 5'd1;
            end
            if (o_fifo_pop)  rptr <= rptr + 5'd1;
            if (o_fifo_mark) mptr <= rptr;
            if (o_fifo_rrst) rptr <= mptr;
        end
    end

    assign i_fifo_front = fmem[rptr[3:0]];
    assign i_fifo_empty = (wptr == rptr);
    assign i_fifo_full  = ((wptr - rptr) == 5'd16);

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    in_q[$];
    logic feed_en, rdy_toggle, lat_en;
    int cyc = 0, mark_cyc = 0, mark_cnt = 0, rrst_cnt = 0, done_cnt = 0;
    int occ_stall = 0, tb_occ = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Queue one sample's expected replay; only the first n_now words go upstream now.
    task automatic load_sample(input int first, input int n_now);
        logic [EXP_W-1:0] rec;
        for (int i = 0; i < n_now; i++) in_q.push_back(DW'(first + i));
        for (int t = 0; t < NT; t++)
            for (int f = 0; f < FC; f++) begin
                rec = {DW'(first + f), FW'(f), TW'(t), (f == FC - 1)};
                exp_q.push_back(rec);
            end
    endtask

    // ---------------- drivers: upstream feeder and engine ready ----------------
    initial begin
        logic fire;
        forever begin
            @(negedge clk);
            fire = i_in_vld && o_in_rdy;
            @(posedge clk);
            #1;
            if (fire && in_q.size() > 0) void'(in_q.pop_front());
            i_in_vld  = feed_en && (in_q.size() > 0);
            i_in_data = (in_q.size() > 0) ? in_q[0] : '0;
            i_feat_rdy = rdy_toggle ? !i_feat_rdy : 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic exp_rdy;
        logic retire_now;
        logic [EXP_W-1:0] got, want;
        if (rst) begin
            tb_occ = 0;
        end else begin
            cyc++;
            retire_now = 1'b0;
            exp_rdy = !i_fifo_full && (tb_occ < DP) && !i_flush;
            check("in_rdy", 32'(o_in_rdy), 32'(exp_rdy));
            if (i_in_vld && !o_in_rdy && !i_fifo_full && !i_flush) occ_stall++;
            if (o_feat_vld && !i_feat_rdy) check("pop_without_rdy", 32'(o_fifo_pop), 0);
            if (o_feat_vld && i_feat_rdy) begin
                got = {o_feat_data, o_feat_idx, o_tree_idx, o_last};
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(got), 0);
                end else begin
                    want = exp_q.pop_front();
                    check("feat_word", 32'(got), 32'(want));
                    retire_now = (o_last && o_tree_idx == TW'(NT - 1));
                end
            end
            if (o_fifo_rrst) rrst_cnt++;
            if (o_sample_done) begin
                done_cnt++;
                if (lat_en) check("mark_to_done_cycles", 32'(cyc - mark_cyc), 32'(LAT));
            end
            if (o_fifo_mark) begin
                mark_cnt++;
                mark_cyc = cyc;
            end
            if (i_flush) tb_occ = 0;
            else tb_occ = tb_occ + ((i_in_vld && o_in_rdy) ? 1 : 0) - (retire_now ? FC : 0);
        end
    end

    // ---------------- sequencing helpers ----------------
    task automatic wait_feed(input int remaining, input int budget);
        int n;
        for (n = 0; n < budget; n++) begin
            if (in_q.size() <= remaining) break;
            @(posedge clk); #1;
        end
        if (n >= budget) timeout("wait_feed");
    endtask

    // i_run is dropped once the last wanted MARK is seen; that sample still completes.
    task automatic run_samples(input int n);
        int m0, d0, k;
        m0 = mark_cnt; d0 = done_cnt;
        i_run = 1'b1;
        for (k = 0; k < 2000; k++) begin
            if (mark_cnt >= m0 + n) break;
            @(posedge clk); #1;
        end
        if (k >= 2000) timeout("wait_mark");
        i_run = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (done_cnt >= d0 + n && !o_busy) break;
            @(posedge clk); #1;
        end
        if (k >= 2000) timeout("wait_done");
    endtask

    // ---------------- scenario table ----------------
    typedef struct {
        int first;
        int n_samples;
        logic toggle;
        logic lat_chk;
        int exp_done;
        int exp_rrst;
        logic exp_occ_stall;
    } scen_t;

    scen_t tab[4];

    initial begin
        int d0, r0, k;
        logic [15:0] c0;

        tab[0] = '{10,  1, 1'b0, 1'b1, 1, 1 * (NT - 1), 1'b0};
        tab[1] = '{10,  3, 1'b0, 1'b1, 3, 3 * (NT - 1), 1'b1};
        tab[2] = '{10,  1, 1'b1, 1'b0, 1, 1 * (NT - 1), 1'b0};
        tab[3] = '{100, 2, 1'b1, 1'b0, 2, 2 * (NT - 1), 1'b0};

        rst = 1'b1; i_run = 1'b0; i_flush = 1'b0; i_in_vld = 1'b0; i_in_data = '0;
        i_feat_rdy = 1'b1; feed_en = 1'b1; rdy_toggle = 1'b0; lat_en = 1'b0;

        // Reset values
        #1;
        check("rst_in_rdy", 32'(o_in_rdy), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_pulses", 32'({o_fifo_mark, o_fifo_rrst, o_fifo_flush, o_sample_done}), 0);
        check("rst_stream", 32'({o_feat_vld, o_fifo_pop, o_last, o_fifo_push}), 0);
        check("rst_idx", 32'({o_feat_idx, o_tree_idx}), 0);
        check("rst_sample_cnt", 32'(o_sample_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Table-driven replay scenarios
        for (int s = 0; s < 4; s++) begin
            rdy_toggle = tab[s].toggle;
            lat_en = tab[s].lat_chk;
            d0 = done_cnt; r0 = rrst_cnt; c0 = o_sample_cnt; occ_stall = 0;
            for (int j = 0; j < tab[s].n_samples; j++) load_sample(tab[s].first + j * FC, FC);
            wait_feed((tab[s].n_samples * FC > DP) ? tab[s].n_samples * FC - DP : 0, 100);
            run_samples(tab[s].n_samples);
            check("scen_done_pulses", 32'(done_cnt - d0), 32'(tab[s].exp_done));
            check("scen_rrst_pulses", 32'(rrst_cnt - r0), 32'(tab[s].exp_rrst));
            check("scen_sample_cnt", 32'(o_sample_cnt - c0), 32'(tab[s].exp_done));
            check("scen_occ_stall", 32'(occ_stall > 0), 32'(tab[s].exp_occ_stall));
            check("scen_exp_drained", 32'(exp_q.size()), 0);
            check("scen_idle", 32'({o_busy, dbg_state}), 32'(ST_IDLE));
            rdy_toggle = 1'b0;
            lat_en = 1'b0;
        end

        // Starvation: only 5 of 8 words available
        d0 = done_cnt;
        load_sample(60, 5);
        wait_feed(0, 50);
        i_run = 1'b1;
        repeat (14) begin @(posedge clk); #1; end
        check("starve_vld", 32'(o_feat_vld), 0);
        check("starve_pop", 32'(o_fifo_pop), 0);
        check("starve_feat_idx", 32'(o_feat_idx), 5);
        check("starve_tree_idx", 32'(o_tree_idx), 0);
        check("starve_state", 32'(dbg_state), 32'(ST_STREAM));
        i_run = 1'b0;
        for (int i = 5; i < FC; i++) in_q.push_back(DW'(60 + i));
        for (k = 0; k < 500; k++) begin
            if (done_cnt > d0 && !o_busy) break;
            @(posedge clk); #1;
        end
        if (k >= 500) timeout("starve_done");
        check("starve_exp_drained", 32'(exp_q.size()), 0);

        // Flush in the middle of pass 2
        load_sample(10, FC);
        wait_feed(0, 50);
        i_run = 1'b1;
        for (k = 0; k < 300; k++) begin
            if (o_feat_vld && o_tree_idx == TW'(2) && o_feat_idx == FW'(3)) break;
            @(posedge clk); #1;
        end
        if (k >= 300) timeout("flush_point");
        c0 = o_sample_cnt;
        i_flush = 1'b1; i_run = 1'b0;
        @(posedge clk); #1;
        i_flush = 1'b0;
        exp_q.delete();
        check("flush_pulse", 32'(o_fifo_flush), 1);
        check("flush_busy", 32'(o_busy), 0);
        check("flush_state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_idx", 32'({o_feat_idx, o_tree_idx}), 0);
        check("flush_sample_cnt", 32'(o_sample_cnt), 32'(c0));
        @(posedge clk); #1;
        check("flush_pulse_width", 32'(o_fifo_flush), 0);
        // With occ cleared, a full DEPTH of new words must be accepted.
        load_sample(40, FC);
        load_sample(48, FC);
        wait_feed(0, 60);
        @(posedge clk); #1;
        check("post_flush_occ_full_rdy", 32'(o_in_rdy), 0);
        run_samples(2);
        check("post_flush_cnt", 32'(o_sample_cnt - c0), 2);
        check("post_flush_drained", 32'(exp_q.size()), 0);

        // Asynchronous reset during REWIND
        load_sample(10, FC);
        wait_feed(0, 50);
        i_run = 1'b1;
        for (k = 0; k < 200; k++) begin
            if (o_fifo_rrst) break;
            @(posedge clk); #1;
        end
        if (k >= 200) timeout("rewind_point");
        check("pre_reset_state", 32'(dbg_state), 32'(ST_REWIND));
        #1 rst = 1'b1;
        #1;
        check("arst_busy", 32'(o_busy), 0);
        check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("arst_pulses", 32'({o_fifo_mark, o_fifo_rrst, o_fifo_flush, o_sample_done}), 0);
        check("arst_stream", 32'({o_feat_vld, o_fifo_pop, o_in_rdy}), 0);
        check("arst_idx", 32'({o_feat_idx, o_tree_idx}), 0);
        check("arst_sample_cnt", 32'(o_sample_cnt), 0);
        in_q.delete();
        exp_q.delete();
        i_run = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        lat_en = 1'b1;
        load_sample(10, FC);
        wait_feed(0, 50);
        run_samples(1);
        check("restart_sample_cnt", 32'(o_sample_cnt), 1);
        check("restart_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
